// File: rtl/feature_map_writer_pkg.sv
// Shared FSM encodings and size helpers for the feature-map writer.
// FEATURE_MAP_WRITER_RELU_EN selects ReLU clamping of written data.
`ifndef LOG2
`define LOG2(x) (((x) <= 1) ? 1 : $clog2(x))
`endif

package feature_map_writer_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_CAPTURE = 2'd1;
  localparam logic [1:0] ST_DONE    = 2'd2;

  function automatic int fmw_out_size(
    input int image_size,
    input int filter_size
  );
    return image_size - filter_size + 1;
  endfunction

  function automatic int fmw_addr_width(
    input int out_size
  );
    return `LOG2(out_size * out_size);
  endfunction

  function automatic int fmw_idx_width(
    input int out_size
  );
    return `LOG2(out_size);
  endfunction

endpackage

// File: rtl/feature_map_addr_gen.sv
// Row/column/linear address counter for one feature-map frame.
// Holds at the final address; the owner clears it per frame.
module feature_map_addr_gen #(
  parameter int OUT_SIZE = 1,
  parameter int AW       = 1,
  parameter int IW       = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          step,
  output logic [AW-1:0] addr,
  output logic          last
);

  localparam logic [IW-1:0] IDX_MAX = IW'(OUT_SIZE - 1);

  logic [IW-1:0] row;
  logic [IW-1:0] col;
  logic          col_wrap;

  assign col_wrap = (col == IDX_MAX);
  assign last     = col_wrap & (row == IDX_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row  <= '0;
      col  <= '0;
      addr <= '0;
    end else if (clear) begin
      row  <= '0;
      col  <= '0;
      addr <= '0;
    end else if (step && !last) begin
      addr <= addr + AW'(1);
      if (col_wrap) begin
        col <= '0;
        row <= row + IW'(1);
      end else begin
        col <= col + IW'(1);
      end
    end
  end

endmodule

// File: rtl/feature_map_writer.sv
// Captures one frame of convolution results into a row-major RAM.
// Define FEATURE_MAP_WRITER_RELU_EN to clamp negative results to 0.
module feature_map_writer
  import feature_map_writer_pkg::*;
#(
  parameter  int FILTER_SIZE = -1,
  parameter  int IMAGE_SIZE  = -1,
  parameter  int DATA_WIDTH  = 16,
  localparam int OUT_SIZE    = fmw_out_size(IMAGE_SIZE, FILTER_SIZE),
  localparam int AW          = fmw_addr_width(OUT_SIZE)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clk_en,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  start,
  input  logic                  done_ack,
  output logic                  wr_en,
  output logic [AW-1:0]         wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  overrun
);

  localparam int IW = fmw_idx_width(OUT_SIZE);

  logic [1:0]            state;
  logic [1:0]            state_nxt;
  logic                  accept;
  logic                  stray;
  logic                  cnt_clear;
  logic                  cnt_last;
  logic [AW-1:0]         cnt_addr;
  logic [DATA_WIDTH-1:0] data_fmt;

`ifdef FEATURE_MAP_WRITER_RELU_EN
  assign data_fmt = in_data[DATA_WIDTH-1] ? '0 : in_data;
`else
  assign data_fmt = in_data;
`endif

  assign accept = (state == ST_CAPTURE) & clk_en & in_valid;
  assign stray  = (state != ST_CAPTURE) & clk_en & in_valid;

  always_comb begin
    state_nxt = state;
    cnt_clear = 1'b0;
    unique case (1'b1)
      (state == ST_IDLE): begin
        if (start) begin
          state_nxt = ST_CAPTURE;
          cnt_clear = 1'b1;
        end
      end
      (state == ST_CAPTURE): begin
        if (accept && cnt_last) begin
          state_nxt = ST_DONE;
        end
      end
      (state == ST_DONE): begin
        if (done_ack && start) begin
          state_nxt = ST_CAPTURE;
          cnt_clear = 1'b1;
        end else if (done_ack) begin
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  feature_map_addr_gen #(
    .OUT_SIZE (OUT_SIZE),
    .AW       (AW),
    .IW       (IW)
  ) u_addr_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (cnt_clear),
    .step  (accept),
    .addr  (cnt_addr),
    .last  (cnt_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Address and data hold their last value between strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      wr_en <= accept;
      if (accept) begin
        wr_addr <= cnt_addr;
        wr_data <= data_fmt;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun <= 1'b0;
    end else if (stray) begin
      overrun <= 1'b1;
    end
  end

  assign busy       = (state == ST_CAPTURE);
  assign frame_done = (state == ST_DONE);

endmodule

// File: doc/feature_map_writer.md
FEATURE_MAP_WRITER -- requirements
Module: feature_map_writer

Interface
REQ-001 SHALL have parameter FILTER_SIZE, default -1, filter edge length; must be overridden with a value from 1 to IMAGE_SIZE.
REQ-002 SHALL have parameter IMAGE_SIZE, default -1, input image edge length; must be overridden.
REQ-003 SHALL have parameter DATA_WIDTH, default 16, signed convolution result width.
REQ-004 SHALL derive OUT_SIZE = IMAGE_SIZE-FILTER_SIZE+1, and AW = `LOG2(OUT_SIZE*OUT_SIZE).
REQ-005 SHALL have port: clk  input  1  sole clock, all state on rising edge.
REQ-006 SHALL have port: rst_n  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port: clk_en  input  1  pipeline advance qualifier, shared with the convolution datapath.
REQ-008 SHALL have port: in_valid  input  1  convolution result valid (window fully inside image).
REQ-009 SHALL have port: in_data  input  DATA_WIDTH  signed convolution result.
REQ-010 SHALL have port: start  input  1  arm capture of one frame.
REQ-011 SHALL have port: done_ack  input  1  consumer acknowledges completed frame.
REQ-012 SHALL have port: wr_en  output  1  feature-map RAM write strobe.
REQ-013 SHALL have port: wr_addr  output  AW  feature-map RAM address, row-major.
REQ-014 SHALL have port: wr_data  output  DATA_WIDTH  feature-map RAM write data.
REQ-015 SHALL have port: busy  output  1  high in CAPTURE.
REQ-016 SHALL have port: frame_done  output  1  high in DONE.
REQ-017 SHALL have port: overrun  output  1  sticky: in_valid accepted-qualified while not in CAPTURE.

Function
REQ-018 SHALL implement FSM states IDLE, CAPTURE, DONE; reset state IDLE.
REQ-019 IDLE: start=1 -> CAPTURE; row, col, addr counters cleared to 0 on the same edge.
REQ-020 CAPTURE: a beat is accepted on an edge where clk_en=1 and in_valid=1; beats with clk_en=0 are ignored.
REQ-021 Each accepted beat SHALL produce, on the next edge, wr_en=1 for exactly one cycle, with wr_addr = row*OUT_SIZE+col and wr_data = in_data (latency 1); wr_en SHALL be 0 at all other times.
REQ-022 col SHALL wrap OUT_SIZE-1 -> 0 and increment row; addr SHALL increment by 1 per beat and never exceed OUT_SIZE*OUT_SIZE-1.
REQ-023 Accepting beat OUT_SIZE*OUT_SIZE-1 (final) SHALL transition to DONE on the same edge that registers its write.
REQ-024 start in CAPTURE SHALL be ignored.
REQ-025 DONE: frame_done=1 and held until done_ack=1 -> IDLE; done_ack and start together -> CAPTURE with counters cleared.
REQ-026 done_ack outside DONE SHALL be ignored.
REQ-027 in_valid=1 with clk_en=1 in IDLE or DONE SHALL not write and SHALL set overrun; overrun is cleared only by reset.

Reset
REQ-028 rst_n=0 SHALL immediately force IDLE, wr_en=0, wr_addr=0, wr_data=0, busy=0, frame_done=0, overrun=0, counters 0, including mid-frame; partial frames are abandoned and not resumed.

Configuration
REQ-029 With FEATURE_MAP_WRITER_RELU_EN defined, wr_data SHALL be 0 when in_data is negative, otherwise in_data.
REQ-030 Without FEATURE_MAP_WRITER_RELU_EN, wr_data SHALL equal in_data unchanged; the port list is identical in both builds.

Structure
REQ-031 FSM state encodings and the OUT_SIZE/AW derivation helpers SHALL live in the shared package, next to the `LOG2 macro.
REQ-032 Row/column/linear address counting SHALL be one sub-module, feature_map_addr_gen; the FSM and data register stay in the top module.

Verification (IMAGE_SIZE=8, FILTER_SIZE=3, OUT_SIZE=6, DATA_WIDTH=16)
REQ-033 Reset release, start, 36 beats of in_valid with clk_en=1 and data 0..35 -> 36 wr_en pulses, addr 0..35, data 0..35; frame_done rises after beat 35.
REQ-034 Same frame with clk_en toggling every other cycle and in_valid held high -> still exactly 36 writes, no duplicates.
REQ-035 in_data=-5 (0xFFFB) -> wr_data=0 with RELU_EN, 0xFFFB without.
REQ-036 in_valid=1, clk_en=1 in IDLE -> no wr_en; overrun=1 and stays set through start, frame and done_ack.
REQ-037 rst_n low after beat 20 -> all outputs 0 asynchronously; a new start then writes from addr 0.
REQ-038 In DONE, done_ack+start together -> busy=1 next cycle, and the next write goes to addr 0.
